// File: rtl/conv_layer_feeder_pkg.sv
// Shared types and constants for the convolution layer operand feeder.
package conv_layer_feeder_pkg;

  localparam int WEIGHT_WORDS = 28;

  typedef enum logic [2:0] {S_IDLE, S_W_RD, S_P_RD, S_GAP, S_DONE} state_e;
  typedef enum logic {PH_W, PH_P} phase_e;

  function automatic int pix_cnt_w(input int img_dim);
    return $clog2(img_dim * img_dim) + 1;
  endfunction

endpackage

// File: rtl/conv_layer_feeder_addr_gen.sv
// Read address generator: weight and pixel pointers run contiguously across
// channels, so each channel's base is simply where the previous one ended.
module feeder_addr_gen import conv_layer_feeder_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int PCW        = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_wbase,
  input  logic [ADDR_WIDTH-1:0] i_pbase,
  input  logic [PCW-1:0]        i_npix,
  input  logic                  i_w_go,
  input  logic                  i_p_go,
  output logic                  o_w_last,
  output logic                  o_p_last,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output phase_e                o_phase
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wptr, r_pptr, r_addr;
  logic [4:0]            r_wcnt;
  logic [PCW-1:0]        r_pcnt;
  logic                  r_rd_en;
  phase_e                r_phase;

  assign o_w_last = (r_wcnt == 5'(WEIGHT_WORDS - 1));
  assign o_p_last = (r_pcnt == i_npix - PCW'(1));
  assign o_rd_en  = r_rd_en;
  assign o_addr   = r_addr;
  assign o_phase  = r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_pptr  <= '0;
      r_addr  <= '0;
      r_wcnt  <= '0;
      r_pcnt  <= '0;
      r_rd_en <= 1'b0;
      r_phase <= PH_W;
    end else begin
      r_rd_en <= 1'b0;
      if (i_load) begin
        r_wptr <= i_wbase;
        r_pptr <= i_pbase;
        r_wcnt <= '0;
        r_pcnt <= '0;
      end else if (i_w_go) begin
        r_rd_en <= 1'b1;
        r_addr  <= r_wptr;
        r_phase <= PH_W;
        r_wptr  <= r_wptr + A_ONE;
        r_wcnt  <= o_w_last ? 5'd0 : r_wcnt + 5'd1;
      end else if (i_p_go) begin
        r_rd_en <= 1'b1;
        r_addr  <= r_pptr;
        r_phase <= PH_P;
        r_pptr  <= r_pptr + A_ONE;
        r_pcnt  <= o_p_last ? '0 : r_pcnt + PCW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_layer_feeder.sv
// Streams per-channel weights then raster pixels from operand memory into a
// convolution layer; final_set marks the last channel, done closes the layer.
module conv_layer_feeder import conv_layer_feeder_pkg::*; #(
  parameter int IMG_DIM    = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           cmd_layer_nr,
  input  logic [7:0]            cmd_num_ch,
  input  logic [7:0]            cmd_img_dim,
  input  logic [ADDR_WIDTH-1:0] cmd_wbase,
  input  logic [ADDR_WIDTH-1:0] cmd_pbase,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rd_data,
  output logic [31:0]           layer_nr,
  output logic                  weight_we,
  output logic [31:0]           weight_data,
  output logic                  conv_en,
  output logic [31:0]           pixel_in,
  output logic                  final_set,
  output logic                  busy,
  output logic                  done
);

  localparam int PCW = pix_cnt_w(IMG_DIM);
  localparam int GCW = $clog2(GAP_CYCLES + 2) + 1;

  state_e         r_state, w_state_nxt;
  logic [31:0]    r_layer_nr, r_weight_data, r_pixel_in;
  logic [7:0]     r_num_ch, r_ch, w_dim;
  logic [PCW-1:0] r_npix, w_npix;
  logic [GCW-1:0] r_gap;
  logic           r_busy, r_done, r_final, r_weight_we, r_conv_en;
  logic           r_s1_vld;
  phase_e         r_s1_ph, w_phase;
  logic           w_accept, w_degen, w_last_ch, w_gap_end;
  logic           w_w_go, w_p_go, w_w_last, w_p_last, w_rd_en, w_s1_w, w_s1_p;

  assign w_dim     = (cmd_img_dim > 8'(IMG_DIM)) ? 8'(IMG_DIM) : cmd_img_dim;
  assign w_npix    = PCW'(w_dim) * PCW'(w_dim);
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_degen   = (cmd_num_ch == 8'd0) || (cmd_img_dim == 8'd0);
  assign w_last_ch = (r_ch == r_num_ch - 8'd1);
  // The last channel also waits out the 2-cycle output pipeline before done.
  assign w_gap_end = w_last_ch ? (r_gap == GCW'(GAP_CYCLES + 1))
                               : (r_gap == GCW'(GAP_CYCLES - 1));
  assign w_w_go    = (r_state == S_W_RD);
  assign w_p_go    = (r_state == S_P_RD);
  assign w_s1_w    = r_s1_vld && (r_s1_ph == PH_W);
  assign w_s1_p    = r_s1_vld && (r_s1_ph == PH_P);

  feeder_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PCW        (PCW)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept),
    .i_wbase  (cmd_wbase),
    .i_pbase  (cmd_pbase),
    .i_npix   (r_npix),
    .i_w_go   (w_w_go),
    .i_p_go   (w_p_go),
    .o_w_last (w_w_last),
    .o_p_last (w_p_last),
    .o_rd_en  (w_rd_en),
    .o_addr   (mem_addr),
    .o_phase  (w_phase)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = w_degen ? S_DONE : S_W_RD;
      S_W_RD: if (w_w_last) w_state_nxt = S_P_RD;
      S_P_RD: if (w_p_last) w_state_nxt = S_GAP;
      S_GAP:  if (w_gap_end) w_state_nxt = w_last_ch ? S_DONE : S_W_RD;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_layer_nr    <= '0;
      r_num_ch      <= '0;
      r_npix        <= '0;
      r_ch          <= '0;
      r_gap         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_final       <= 1'b0;
      r_s1_vld      <= 1'b0;
      r_s1_ph       <= PH_W;
      r_weight_we   <= 1'b0;
      r_weight_data <= '0;
      r_conv_en     <= 1'b0;
      r_pixel_in    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_layer_nr <= cmd_layer_nr;
        r_num_ch   <= cmd_num_ch;
        r_npix     <= w_npix;
        r_ch       <= '0;
        r_busy     <= 1'b1;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
      end
      if (r_state == S_GAP && w_state_nxt == S_W_RD) r_ch <= r_ch + 8'd1;
      r_gap <= (r_state == S_GAP && w_state_nxt == S_GAP) ? r_gap + GCW'(1) : '0;

      // Read issued at t, data valid at t+1, presented at t+2.
      r_s1_vld      <= w_rd_en;
      r_s1_ph       <= w_phase;
      r_weight_we   <= w_s1_w;
      r_weight_data <= w_s1_w ? mem_rd_data : '0;
      r_conv_en     <= w_s1_p;
      r_pixel_in    <= w_s1_p ? mem_rd_data : '0;

      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE)           r_final <= 1'b0;
      else if (w_s1_w && w_last_ch)    r_final <= 1'b1;
    end
  end

  assign mem_rd_en   = w_rd_en;
  assign layer_nr    = r_layer_nr;
  assign weight_we   = r_weight_we;
  assign weight_data = r_weight_data;
  assign conv_en     = r_conv_en;
  assign pixel_in    = r_pixel_in;
  assign final_set   = r_final;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_conv_layer_feeder.sv
// Directed bench for conv_layer_feeder; operand memory returns its own address.
module tb_conv_layer_feeder;

  logic        clk, reset, start;
  logic [31:0] cmd_layer_nr;
  logic [7:0]  cmd_num_ch, cmd_img_dim;
  logic [15:0] cmd_wbase, cmd_pbase;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] layer_nr, weight_data, pixel_in;
  logic        weight_we, conv_en, final_set, busy, done;

  int checks = 0;
  int errors = 0;

  int o_first_we, o_last_we, o_n_we, o_first_en, o_last_en, o_n_en;
  int o_done_k, o_n_done, o_fs_first, o_n_rd, o_bad, o_overlap, o_rst_viol;
  int o_nws, o_nce;
  int o_ws [8];
  int o_ce [8];
  logic [31:0] o_wd0 [8];
  logic [31:0] o_pd0 [8];
  logic [31:0] o_pd16, o_layer;
  logic o_busy0, o_busy_done, o_fs_done;

  conv_layer_feeder dut (
    .clk(clk), .reset(reset), .start(start),
    .cmd_layer_nr(cmd_layer_nr), .cmd_num_ch(cmd_num_ch), .cmd_img_dim(cmd_img_dim),
    .cmd_wbase(cmd_wbase), .cmd_pbase(cmd_pbase),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .layer_nr(layer_nr), .weight_we(weight_we), .weight_data(weight_data),
    .conv_en(conv_en), .pixel_in(pixel_in), .final_set(final_set),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= mem_rd_en ? {16'h0, mem_addr} : 32'hDEAD_BEEF;

  // Issues one command (accepted at edge T) and records what happens at k cycles after T.
  task automatic run_cmd(input logic [31:0] lnr, input logic [7:0] nch, input logic [7:0] dim,
                         input logic [15:0] wb, input logic [15:0] pb,
                         input int inj_k, input int rst_k, input int max_k);
    logic pw, pe;
    logic [15:0] ea;
    o_first_we = -1; o_last_we = -1; o_n_we = 0; o_first_en = -1; o_last_en = -1; o_n_en = 0;
    o_done_k = -1; o_n_done = 0; o_fs_first = -1; o_n_rd = 0; o_bad = 0; o_overlap = 0;
    o_rst_viol = 0; o_nws = 0; o_nce = 0; o_pd16 = 32'hFFFF_FFFF;
    o_busy_done = 1'b1; o_fs_done = 1'b1;
    for (int i = 0; i < 8; i++) begin o_ws[i] = -1; o_ce[i] = -1; o_wd0[i] = '0; o_pd0[i] = '0; end
    pw = 1'b0; pe = 1'b0;
    @(negedge clk);
    cmd_layer_nr = lnr; cmd_num_ch = nch; cmd_img_dim = dim;
    cmd_wbase = wb; cmd_pbase = pb; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < max_k; k++) begin
      @(negedge clk);
      if (k == 0) begin o_layer = layer_nr; o_busy0 = busy; end
      if (mem_rd_en) o_n_rd++;
      if (weight_we && conv_en) o_overlap++;
      if (weight_we) begin
        ea = wb + 16'(o_n_we);
        if (weight_data !== {16'h0, ea}) o_bad++;
        if (!pw && o_nws < 8) begin o_ws[o_nws] = k; o_wd0[o_nws] = weight_data; o_nws++; end
        if (o_first_we < 0) o_first_we = k;
        o_last_we = k; o_n_we++;
      end else if (weight_data !== 32'h0) o_bad++;
      if (conv_en) begin
        ea = pb + 16'(o_n_en);
        if (pixel_in !== {16'h0, ea}) o_bad++;
        if (!pe && o_nws > 0 && o_nws <= 8) o_pd0[o_nws-1] = pixel_in;
        if (o_n_en == 16) o_pd16 = pixel_in;
        if (o_first_en < 0) o_first_en = k;
        o_last_en = k; o_n_en++;
      end else if (pixel_in !== 32'h0) o_bad++;
      if (!conv_en && pe && o_nce < 8) begin o_ce[o_nce] = k - 1; o_nce++; end
      if (final_set && o_fs_first < 0) o_fs_first = k;
      if (done) begin
        o_n_done++;
        if (o_done_k < 0) begin o_done_k = k; o_busy_done = busy; o_fs_done = final_set; end
      end
      if (rst_k >= 0 && k == rst_k + 1)
        if (weight_we || conv_en || busy || final_set || done || mem_rd_en) o_rst_viol++;
      pw = weight_we; pe = conv_en;
      start = (k == inj_k);
      if (k == inj_k) begin cmd_num_ch = 8'd0; cmd_layer_nr = 32'h99; cmd_wbase = 16'h0500; end
      if (k == rst_k) reset = 1'b1;
      if (k == rst_k + 1) reset = 1'b0;
      if (o_done_k >= 0 && k >= o_done_k + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    int act;
    reset = 1'b1; start = 1'b0; cmd_layer_nr = '0; cmd_num_ch = '0; cmd_img_dim = '0;
    cmd_wbase = '0; cmd_pbase = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_rd_en, weight_we, conv_en, final_set, busy, done} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 000000", {mem_rd_en, weight_we, conv_en, final_set, busy, done});
    end
    checks++;
    if ({layer_nr, weight_data, pixel_in, mem_addr} !== 112'h0) begin
      errors++; $display("FAIL reset_data layer %h wd %h px %h addr %h exp all 0", layer_nr, weight_data, pixel_in, mem_addr);
    end
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd_en || busy || weight_we || conv_en || done) act++;
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL idle_activity got %0d exp 0", act); end
  endtask

  task automatic test_single;
    run_cmd(32'h0A, 8'd1, 8'd4, 16'h0100, 16'h0200, -1, -1, 200);
    checks++; if (o_layer !== 32'h0A) begin errors++; $display("FAIL single_layer got %h exp 0000000a", o_layer); end
    checks++; if (o_busy0 !== 1'b1) begin errors++; $display("FAIL single_busy_T got %b exp 1", o_busy0); end
    checks++; if (o_first_we != 3) begin errors++; $display("FAIL single_first_we got %0d exp 3", o_first_we); end
    checks++; if (o_last_we != 30) begin errors++; $display("FAIL single_last_we got %0d exp 30", o_last_we); end
    checks++; if (o_n_we != 28) begin errors++; $display("FAIL single_n_we got %0d exp 28", o_n_we); end
    checks++; if (o_first_en != 31) begin errors++; $display("FAIL single_first_en got %0d exp 31", o_first_en); end
    checks++; if (o_last_en != 46) begin errors++; $display("FAIL single_last_en got %0d exp 46", o_last_en); end
    checks++; if (o_n_en != 16) begin errors++; $display("FAIL single_n_en got %0d exp 16", o_n_en); end
    checks++; if (o_done_k != 51) begin errors++; $display("FAIL single_done got %0d exp 51", o_done_k); end
    checks++; if (o_n_done != 1) begin errors++; $display("FAIL single_n_done got %0d exp 1", o_n_done); end
    checks++; if (o_fs_first != 3) begin errors++; $display("FAIL single_final_set got %0d exp 3", o_fs_first); end
    checks++; if (o_bad != 0) begin errors++; $display("FAIL single_data got %0d bad exp 0", o_bad); end
    checks++; if (o_overlap != 0) begin errors++; $display("FAIL single_overlap got %0d exp 0", o_overlap); end
    checks++; if (o_n_rd != 44) begin errors++; $display("FAIL single_reads got %0d exp 44", o_n_rd); end
    checks++; if ({o_busy_done, o_fs_done} !== 2'b00) begin
      errors++; $display("FAIL single_at_done busy/final got %b exp 00", {o_busy_done, o_fs_done});
    end
  endtask

  task automatic test_multi;
    run_cmd(32'h3, 8'd3, 8'd2, 16'h0100, 16'h0200, -1, -1, 300);
    checks++; if (o_ws[0] != 3 || o_ws[1] != 39 || o_ws[2] != 75) begin
      errors++; $display("FAIL multi_w_starts got %0d %0d %0d exp 3 39 75", o_ws[0], o_ws[1], o_ws[2]);
    end
    checks++; if (o_ws[1] - o_ce[0] - 1 != 4 || o_ws[2] - o_ce[1] - 1 != 4) begin
      errors++; $display("FAIL multi_gap got %0d %0d exp 4 4", o_ws[1] - o_ce[0] - 1, o_ws[2] - o_ce[1] - 1);
    end
    checks++; if (o_wd0[2] !== 32'h138) begin errors++; $display("FAIL multi_ch2_waddr got %h exp 00000138", o_wd0[2]); end
    checks++; if (o_pd0[2] !== 32'h208) begin errors++; $display("FAIL multi_ch2_paddr got %h exp 00000208", o_pd0[2]); end
    checks++; if (o_fs_first != 75) begin errors++; $display("FAIL multi_final_set got %0d exp 75", o_fs_first); end
    checks++; if (o_done_k != 111) begin errors++; $display("FAIL multi_done got %0d exp 111", o_done_k); end
    checks++; if (o_n_we != 84 || o_n_en != 12) begin
      errors++; $display("FAIL multi_counts got we %0d en %0d exp 84 12", o_n_we, o_n_en);
    end
    checks++; if (o_bad != 0 || o_overlap != 0) begin
      errors++; $display("FAIL multi_data got bad %0d overlap %0d exp 0 0", o_bad, o_overlap);
    end
  endtask

  task automatic test_busy_start;
    run_cmd(32'h55, 8'd1, 8'd2, 16'h0100, 16'h0200, 10, -1, 200);
    checks++; if (o_layer !== 32'h55 || layer_nr !== 32'h55) begin
      errors++; $display("FAIL busy_start_layer got %h/%h exp 00000055", o_layer, layer_nr);
    end
    checks++; if (o_done_k != 39 || o_n_done != 1) begin
      errors++; $display("FAIL busy_start_done got %0d x%0d exp 39 x1", o_done_k, o_n_done);
    end
    checks++; if (o_n_we != 28 || o_n_en != 4 || o_bad != 0) begin
      errors++; $display("FAIL busy_start_xfer got we %0d en %0d bad %0d exp 28 4 0", o_n_we, o_n_en, o_bad);
    end
  endtask

  task automatic test_degenerate;
    run_cmd(32'h77, 8'd0, 8'd4, 16'h0100, 16'h0200, -1, -1, 50);
    checks++; if (o_done_k != 1 || o_n_done != 1) begin
      errors++; $display("FAIL degen_ch_done got %0d x%0d exp 1 x1", o_done_k, o_n_done);
    end
    checks++; if (o_n_rd != 0 || o_n_we != 0 || o_n_en != 0) begin
      errors++; $display("FAIL degen_ch_traffic got rd %0d we %0d en %0d exp 0 0 0", o_n_rd, o_n_we, o_n_en);
    end
    checks++; if (o_layer !== 32'h77 || o_busy0 !== 1'b1 || o_busy_done !== 1'b0) begin
      errors++; $display("FAIL degen_ch_status got layer %h busy %b/%b exp 00000077 1/0", o_layer, o_busy0, o_busy_done);
    end
    run_cmd(32'h78, 8'd2, 8'd0, 16'h0100, 16'h0200, -1, -1, 50);
    checks++; if (o_done_k != 1 || o_n_rd != 0 || o_n_we != 0 || o_n_en != 0) begin
      errors++; $display("FAIL degen_dim got done %0d rd %0d exp 1 0", o_done_k, o_n_rd);
    end
  endtask

  task automatic test_clamp_wrap;
    run_cmd(32'h1, 8'd1, 8'd40, 16'h0010, 16'hFFF0, -1, -1, 1200);
    checks++; if (o_n_en != 1024) begin errors++; $display("FAIL clamp_n_en got %0d exp 1024", o_n_en); end
    checks++; if (o_first_en != 31 || o_last_en != 1054) begin
      errors++; $display("FAIL clamp_en_span got %0d..%0d exp 31..1054", o_first_en, o_last_en);
    end
    checks++; if (o_done_k != 1059) begin errors++; $display("FAIL clamp_done got %0d exp 1059", o_done_k); end
    checks++; if (o_pd0[0] !== 32'hFFF0 || o_pd16 !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got first %h idx16 %h exp 0000fff0 00000000", o_pd0[0], o_pd16);
    end
    checks++; if (o_bad != 0) begin errors++; $display("FAIL clamp_data got %0d bad exp 0", o_bad); end
  endtask

  task automatic test_reset_mid;
    run_cmd(32'h2, 8'd1, 8'd4, 16'h0100, 16'h0200, -1, 35, 120);
    checks++; if (o_rst_viol != 0) begin errors++; $display("FAIL rst_mid_outputs got %0d active exp 0", o_rst_viol); end
    checks++; if (o_n_done != 0) begin errors++; $display("FAIL rst_mid_done got %0d exp 0", o_n_done); end
    run_cmd(32'h3, 8'd1, 8'd4, 16'h0300, 16'h0400, -1, -1, 200);
    checks++; if (o_done_k != 51 || o_n_we != 28 || o_n_en != 16) begin
      errors++; $display("FAIL rst_mid_rerun got done %0d we %0d en %0d exp 51 28 16", o_done_k, o_n_we, o_n_en);
    end
    checks++; if (o_bad != 0 || o_wd0[0] !== 32'h300 || o_pd0[0] !== 32'h400) begin
      errors++; $display("FAIL rst_mid_rerun_data got bad %0d w0 %h p0 %h exp 0 300 400", o_bad, o_wd0[0], o_pd0[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_busy_start();
    test_degenerate();
    test_clamp_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
